// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PC-addressed reads to a synchronous memory and buffers tagged returns.
// Optional FETCH_BYPASS_EN presents return data directly when the queue is empty.
module fetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        pc,
    output logic                     pc_advance,
    input  logic                     flush,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [INSTR_W-1:0]       mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [INSTR_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [MEM_LAT-1:0] tag_valid;
    logic [ADDR_W-1:0]  tag_pc [MEM_LAT];

    logic [PTR_W-1:0]   inflight;
    logic [PTR_W:0]     credit_used;
    logic               fifo_empty, fifo_full;
    logic               issue, ret_valid, bypass, push, head_pop;
    logic [ADDR_W-1:0]  ret_pc;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++)
            inflight = inflight + PTR_W'(tag_valid[i]);
    end

    assign count       = wr_ptr - rd_ptr;
    assign credit_used = {1'b0, count} + {1'b0, inflight};
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                         (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    // Credit uses registered occupancy only, so instr_ready never reaches mem_req.
    assign issue      = reset_n && !flush && (credit_used < DEPTH_C);
    assign mem_req    = issue;
    assign pc_advance = issue;
    assign mem_addr   = pc;

    assign ret_valid = tag_valid[MEM_LAT-1];
    assign ret_pc    = tag_pc[MEM_LAT-1];

    // Decoder handshake: an entry transfers on a cycle where instr_valid && instr_ready;
    // while instr_valid is high and instr_ready low, instr/instr_pc hold their value.
`ifdef FETCH_BYPASS_EN
    assign bypass = ret_valid && fifo_empty && !flush;
    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (!fifo_empty) begin
            instr_valid = 1'b1;
            instr       = data_q[rd_ptr[IDX_W-1:0]];
            instr_pc    = addr_q[rd_ptr[IDX_W-1:0]];
        end else if (bypass) begin
            instr_valid = 1'b1;
            instr       = mem_rdata;
            instr_pc    = ret_pc;
        end
    end
`else
    assign bypass = 1'b0;
    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (!fifo_empty) begin
            instr_valid = 1'b1;
            instr       = data_q[rd_ptr[IDX_W-1:0]];
            instr_pc    = addr_q[rd_ptr[IDX_W-1:0]];
        end
    end
`endif

    assign head_pop = instr_valid && instr_ready && !fifo_empty;
    assign push     = ret_valid && !flush && !(bypass && instr_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_valid <= '0;
            for (int i = 0; i < MEM_LAT; i++) tag_pc[i] <= '0;
        end else begin
            for (int i = MEM_LAT - 1; i > 0; i--) tag_pc[i] <= tag_pc[i-1];
            tag_pc[0] <= pc;
            if (flush) begin
                // Squash everything: returning data for invalidated tags is dropped.
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                tag_valid <= '0;
            end else begin
                if (push)     wr_ptr <= wr_ptr + 1'b1;
                if (head_pop) rd_ptr <= rd_ptr + 1'b1;
                for (int i = MEM_LAT - 1; i > 0; i--) tag_valid[i] <= tag_valid[i-1];
                tag_valid[0] <= issue;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr[IDX_W-1:0]] <= mem_rdata;
            addr_q[wr_ptr[IDX_W-1:0]] <= ret_pc;
        end
    end

    no_overflow_a: assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full));

endmodule
